// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encodings, CPOL/CPHA bit positions and the default idle word.
package spi_pkg;
  typedef enum logic [1:0] {MODE0 = 2'd0, MODE1 = 2'd1, MODE2 = 2'd2, MODE3 = 2'd3} spi_mode_e;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam logic [31:0] IDLE_WORD_DEFAULT = '1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra pointer bit; push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk6x,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic full, do_push, do_pop;
  assign pop_valid = wr_ptr != rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && pop_valid;
  assign push_ready = !full || do_pop;
  assign do_push = push && push_ready;
  // Head reads as zero when empty so the output has a defined reset value without clearing storage.
  assign pop_data = pop_valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk6x or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk6x)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/spi_target_fifo.sv
// spi_target_fifo: SPI target, run-time selectable mode, configurable word width,
// RX/TX FIFOs with valid/ready handshakes and overrun/underrun pulses.
module spi_target_fifo import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT[DATA_W-1:0]
) (
  input  logic              clk6x,
  input  logic              reset,
  input  logic              spi_clk_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_drive_o,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_first_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [1:0] sck_s, csn_s, mosi_s;
  logic sck_q, csn_q, active, first;
  spi_mode_e mode_q;
  logic [CW-1:0] cnt;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] tx_sh, tx_head, rx_word;
  logic sck_rise, sck_fall, csn_fall, sel, same, samp, shft, load, rx_done, rx_in_ready, tx_avail;
  assign sck_rise = sck_s[1] && !sck_q;
  assign sck_fall = !sck_s[1] && sck_q;
  assign csn_fall = !csn_s[1] && csn_q;
  assign sel = active && !csn_s[1];
  assign same = mode_q[CPOL_BIT] == mode_q[CPHA_BIT];
  assign samp = sel && (same ? sck_rise : sck_fall);
  assign shft = sel && (same ? sck_fall : sck_rise);
  // A shift edge with an empty bit count always starts a word; CPHA=0 also preloads at select.
  assign load = (csn_fall && !mode_i[CPHA_BIT]) || (shft && cnt == '0);
  assign rx_done = samp && cnt == CW'(DATA_W - 1);
  assign rx_word = {rx_sh, mosi_s[1]};
  assign rx_overrun_o = rx_done && !rx_in_ready;
  assign tx_underrun_o = load && !tx_avail;
  assign spi_miso_drive_o = active;
  assign busy_o = active;
  assign spi_miso_o = active ? tx_sh[DATA_W-1] : (tx_avail ? tx_head[DATA_W-1] : IDLE_WORD[DATA_W-1]);
  // Synchronisers reset low so a CSN held low through reset never looks like a new falling edge.
  always_ff @(posedge clk6x or posedge reset)
    if (reset) begin
      sck_s <= '0;
      csn_s <= '0;
      mosi_s <= '0;
      sck_q <= 1'b0;
      csn_q <= 1'b0;
      active <= 1'b0;
      mode_q <= MODE0;
      cnt <= '0;
      first <= 1'b1;
      rx_sh <= '0;
      tx_sh <= IDLE_WORD;
    end else begin
      sck_s <= {sck_s[0], spi_clk_i};
      csn_s <= {csn_s[0], spi_csn_i};
      mosi_s <= {mosi_s[0], spi_mosi_i};
      sck_q <= sck_s[1];
      csn_q <= csn_s[1];
      if (csn_fall) begin
        active <= 1'b1;
        mode_q <= spi_mode_e'(mode_i);
      end else if (csn_s[1]) active <= 1'b0;
      if (!sel) begin
        cnt <= '0;
        first <= 1'b1;
      end else if (samp) begin
        cnt <= rx_done ? '0 : cnt + 1'b1;
        rx_sh <= rx_word[DATA_W-2:0];
        if (rx_done) first <= 1'b0;
      end
      if (load) tx_sh <= tx_avail ? tx_head : IDLE_WORD;
      else if (shft) tx_sh <= {tx_sh[DATA_W-2:0], 1'b1};
    end
  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk6x(clk6x),
    .reset(reset),
    .push(rx_done),
    .push_data({first, rx_word}),
    .push_ready(rx_in_ready),
    .pop(rx_ready_i),
    .pop_data({rx_first_o, rx_data_o}),
    .pop_valid(rx_valid_o)
  );
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk6x(clk6x),
    .reset(reset),
    .push(tx_valid_i),
    .push_data(tx_data_i),
    .push_ready(tx_ready_o),
    .pop(load),
    .pop_data(tx_head),
    .pop_valid(tx_avail)
  );
endmodule
